// File: rtl/fx_match_arbiter.sv
// fx_match_arbiter: round-robin sharing of one fixed-latency format-match datapath among NREQ requesters.
// Define FXM_ARB_STATS_EN to add per-requester saturating grant counters (grant_cnt, stats_clr).
module fx_match_arbiter #(
  parameter int NREQ   = 4,
  parameter int W_IN   = 13,
  parameter int W_OUT  = 13,
  parameter int DP_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*W_IN-1:0]   req_data,
  output logic                   dp_i_valid,
  output logic [W_IN-1:0]        dp_i_data,
  input  logic [W_OUT-1:0]       dp_o_data,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [W_OUT-1:0]       rsp_data,
  output logic                   busy
`ifdef FXM_ARB_STATS_EN
  ,
  input  logic                   stats_clr,
  output logic [NREQ*16-1:0]     grant_cnt
`endif
);
  localparam int IW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_rr, w_win, r_dp_idx, w_ti;
  logic w_found, w_grant, r_dp_v, w_tv, w_pipe_any, w_empty;
  logic [W_IN-1:0] r_dp_data;
  logic [NREQ-1:0] r_rsp_valid;
  logic [W_OUT-1:0] r_rsp_data;
  // Scan farthest-to-nearest from rr+1 so the nearest requester is written last and wins.
  always_comb begin
    w_win = '0;
    w_found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      if (req_valid[IW'((int'(r_rr) + k) % NREQ)]) begin
        w_win = IW'((int'(r_rr) + k) % NREQ);
        w_found = 1'b1;
      end
    end
  end
  assign w_grant = w_found & en & (r_state == RUN);
  assign req_ready = w_grant ? (NREQ'(1) << w_win) : '0;
  assign w_empty = ~r_dp_v & ~w_pipe_any & ~(|r_rsp_valid);
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (en ? RUN : IDLE) :
             (r_state == RUN)  ? (en ? RUN : DRAIN) :
                                 (en ? RUN : (w_empty ? IDLE : DRAIN));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_rr <= IW'(NREQ - 1);
      r_dp_v <= 1'b0;
      r_dp_data <= '0;
      r_dp_idx <= '0;
      r_rsp_valid <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_next;
      r_dp_v <= w_grant;
      if (w_grant) begin
        r_rr <= w_win;
        r_dp_data <= req_data[int'(w_win)*W_IN +: W_IN];
        r_dp_idx <= w_win;
      end
      r_rsp_valid <= w_tv ? (NREQ'(1) << w_ti) : '0;
      if (w_tv) r_rsp_data <= dp_o_data;
    end
  end
  // Tag pipe mirrors the external datapath latency so each result meets its requester index.
  if (DP_LAT == 0) begin : g_wire
    assign w_tv = r_dp_v;
    assign w_ti = r_dp_idx;
    assign w_pipe_any = 1'b0;
  end else begin : g_pipe
    logic [DP_LAT-1:0] r_pv;
    logic [IW-1:0] r_pi [DP_LAT];
    always_ff @(posedge clk) begin
      if (rst) begin
        r_pv <= '0;
        for (int i = 0; i < DP_LAT; i++) r_pi[i] <= '0;
      end else begin
        r_pv[0] <= r_dp_v;
        r_pi[0] <= r_dp_idx;
        for (int i = 1; i < DP_LAT; i++) begin
          r_pv[i] <= r_pv[i-1];
          r_pi[i] <= r_pi[i-1];
        end
      end
    end
    assign w_tv = r_pv[DP_LAT-1];
    assign w_ti = r_pi[DP_LAT-1];
    assign w_pipe_any = |r_pv;
  end
  assign dp_i_valid = r_dp_v;
  assign dp_i_data = r_dp_data;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data = r_rsp_data;
  assign busy = (r_state != IDLE) | r_dp_v | w_pipe_any | (|r_rsp_valid);
`ifdef FXM_ARB_STATS_EN
  logic [15:0] r_cnt [NREQ];
  // A clear coinciding with a grant leaves that grant counted.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst) r_cnt[i] <= '0;
      else if (stats_clr) r_cnt[i] <= {15'd0, w_grant && (w_win == IW'(i))};
      else if (w_grant && (w_win == IW'(i)) && (r_cnt[i] != 16'hFFFF)) r_cnt[i] <= r_cnt[i] + 16'd1;
    end
  end
  for (genvar n = 0; n < NREQ; n++) begin : g_cnt
    assign grant_cnt[n*16 +: 16] = r_cnt[n];
  end
`endif
endmodule

// File: tb/tb_fx_match_arbiter.sv
// tb_fx_match_arbiter: randomized bench for fx_match_arbiter against a queue-based reference model.
module tb_fx_match_arbiter;
  localparam int NREQ = 4, W_IN = 13, W_OUT = 13, DP_LAT = 1;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [NREQ-1:0] req_valid = '0, req_ready, rsp_valid;
  logic [NREQ*W_IN-1:0] req_data = '0;
  logic dp_i_valid, busy;
  logic [W_IN-1:0] dp_i_data;
  logic [W_OUT-1:0] dp_o_data = '0, rsp_data;
`ifdef FXM_ARB_STATS_EN
  logic stats_clr = 1'b0;
  logic [NREQ*16-1:0] grant_cnt;
`endif
  always #5 clk = ~clk;
  fx_match_arbiter #(.NREQ(NREQ), .W_IN(W_IN), .W_OUT(W_OUT), .DP_LAT(DP_LAT)) dut (
    .clk(clk), .rst(rst), .en(en), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .dp_i_valid(dp_i_valid), .dp_i_data(dp_i_data),
    .dp_o_data(dp_o_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
`ifdef FXM_ARB_STATS_EN
    , .stats_clr(stats_clr), .grant_cnt(grant_cnt)
`endif
  );
  function automatic logic [W_OUT-1:0] fx(input logic [W_IN-1:0] x);
    return W_OUT'(x * 13'd3 + 13'd1);
  endfunction
  // One-cycle stand-in for the external converter chain.
  always @(posedge clk) dp_o_data <= fx(dp_i_data);
  typedef struct {int due; int idx; logic [W_OUT-1:0] d;} rsp_t;
  rsp_t q[$];
  int cyc = 0, m_state = 0, m_rr = NREQ - 1, n_chk = 0, n_err = 0;
  int m_cnt [NREQ];
  logic m_iv = 1'b0;
  logic [W_IN-1:0] m_last = '0;
  logic [W_OUT-1:0] m_rsp = '0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask
  function automatic int pick(input logic [NREQ-1:0] v);
    int best = -1, bd = NREQ;
    for (int i = 0; i < NREQ; i++)
      if (v[i] && ((i - m_rr - 1 + 2*NREQ) % NREQ) < bd) begin
        bd = (i - m_rr - 1 + 2*NREQ) % NREQ;
        best = i;
      end
    return best;
  endfunction
  function automatic logic [NREQ*W_IN-1:0] rnd();
    logic [NREQ*W_IN-1:0] r;
    for (int i = 0; i < NREQ; i++) r[i*W_IN +: W_IN] = W_IN'($urandom);
    return r;
  endfunction
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    m_state = 0; m_rr = NREQ - 1; m_last = '0; m_rsp = '0; m_iv = 1'b0;
    for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
  endtask
  task automatic step(input logic e, input logic [NREQ-1:0] v, input logic [NREQ*W_IN-1:0] d);
    int w;
    logic clr;
    logic was_empty;
    logic [NREQ-1:0] exp_rv;
    @(negedge clk);
    was_empty = (q.size() == 0);
    chk("busy", busy, (m_state != 0) || !was_empty);
    exp_rv = '0;
    if (!was_empty && q[0].due == cyc) begin
      exp_rv = NREQ'(1) << q[0].idx;
      m_rsp = q[0].d;
      void'(q.pop_front());
    end
    chk("rsp_valid", rsp_valid, exp_rv);
    chk("rsp_data", rsp_data, m_rsp);
    chk("dp_i_valid", dp_i_valid, m_iv);
    chk("dp_i_data", dp_i_data, m_last);
    clr = 1'b0;
`ifdef FXM_ARB_STATS_EN
    for (int i = 0; i < NREQ; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], 16'(m_cnt[i]));
    clr = ($urandom_range(0, 15) == 0);
    stats_clr = clr;
`endif
    en = e; req_valid = v; req_data = d;
    #1;
    w = (m_state == 1 && e) ? pick(v) : -1;
    chk("req_ready", req_ready, (w < 0) ? '0 : (NREQ'(1) << w));
    m_iv = (w >= 0);
    if (w >= 0) begin
      m_rr = w;
      m_last = d[w*W_IN +: W_IN];
      q.push_back('{due: cyc + DP_LAT + 2, idx: w, d: fx(m_last)});
    end
    for (int i = 0; i < NREQ; i++)
      m_cnt[i] = clr ? int'(w == i) : (w == i && m_cnt[i] < 16'hFFFF) ? m_cnt[i] + 1 : m_cnt[i];
    m_state = (m_state == 0) ? (e ? 1 : 0) : (m_state == 1) ? (e ? 1 : 2) : (e ? 1 : (was_empty ? 0 : 2));
    @(posedge clk);
    cyc++;
  endtask
  initial begin
    logic [NREQ*W_IN-1:0] d;
    do_reset();
    step(1'b0, '0, '0);
    step(1'b1, '0, '0);
    d = rnd();
    d[2*W_IN +: W_IN] = 13'h0155;
    step(1'b1, 4'b0100, d);
    repeat (4) step(1'b1, '0, rnd());
    repeat (8) step(1'b1, 4'b1111, rnd());
    step(1'b1, 4'b0010, rnd());
    repeat (6) step(1'b1, 4'b1010, rnd());
    repeat (4) step(1'b1, 4'b1111, rnd());
    repeat (10) step(1'b0, 4'(($urandom)), rnd());
    step(1'b1, '0, '0);
    repeat (3) step(1'b1, 4'b1111, rnd());
    do_reset();
    repeat (3) step(1'b1, 4'b1111, rnd());
    repeat (500) step($urandom_range(0, 9) != 0, 4'($urandom), rnd());
    repeat (10) step(1'b0, '0, '0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
